// File: rtl/hardware_adder_64bit_pipe.sv
// hardware_adder_64bit_pipe
//   64-bit adder split into N = 64/SLICE_W carry-pipelined slices with a
//   valid/ready handshake on both sides. All stages advance together when the
//   output register is empty or being taken, so in_ready is that same signal.
//   Optional macro HW_ADDER_FLAGS_EN adds c_carry (unsigned carry out of bit
//   63) and c_ovf (signed overflow), registered in step with c.
module hardware_adder_64bit_pipe #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] c
`ifdef HW_ADDER_FLAGS_EN
  ,
  output logic        c_carry,
  output logic        c_ovf
`endif
);

  localparam int N = 64 / SLICE_W;

  // Per-stage state. Operand and carry registers are only meaningful for
  // stages that still have upper slices to hand on (k < N-1).
  logic        r_vld [N];
  logic [63:0] r_a   [N];
  logic [63:0] r_b   [N];
  logic [63:0] r_sum [N];
  logic        r_cy  [N];

  logic              w_adv;
  logic [63:0]       w_a_in     [N];
  logic [63:0]       w_b_in     [N];
  logic [63:0]       w_sum_in   [N];
  logic [63:0]       w_sum_nxt  [N];
  logic              w_cin      [N];
  logic              w_vld_in   [N];
  logic [SLICE_W:0]  w_add      [N];

  // Whole pipe moves only when the last stage is empty or being consumed.
  assign w_adv     = !r_vld[N-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[N-1];
  assign c         = r_sum[N-1];

  // Per-stage slice add: stage k sums slice k plus the carry held by stage k-1.
  always_comb begin
    // NOTE: every element is assigned on every pass, so no latch can form.
    w_a_in[0]   = a;
    w_b_in[0]   = b;
    w_sum_in[0] = '0;
    w_cin[0]    = 1'b0;
    w_vld_in[0] = in_valid;
    for (int k = 1; k < N; k++) begin
      w_a_in[k]   = r_a[k-1];
      w_b_in[k]   = r_b[k-1];
      w_sum_in[k] = r_sum[k-1];
      w_cin[k]    = r_cy[k-1];
      w_vld_in[k] = r_vld[k-1];
    end
    for (int k = 0; k < N; k++) begin
      w_add[k] = {1'b0, w_a_in[k][k*SLICE_W +: SLICE_W]}
               + {1'b0, w_b_in[k][k*SLICE_W +: SLICE_W]}
               + {{SLICE_W{1'b0}}, w_cin[k]};
      w_sum_nxt[k] = w_sum_in[k];
      w_sum_nxt[k][k*SLICE_W +: SLICE_W] = w_add[k][SLICE_W-1:0];
    end
  end

  // Stage registers: valid bits, partial sums, delayed operands and carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath is reset too, so c reads 0 after reset rather than X.
      for (int k = 0; k < N; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_cy[k]  <= 1'b0;
      end
    end else if (w_adv) begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      for (int k = 0; k < N; k++) begin
        r_vld[k] <= w_vld_in[k];
        r_sum[k] <= w_sum_nxt[k];
        if (k < N-1) begin
          r_a[k]  <= w_a_in[k];
          r_b[k]  <= w_b_in[k];
          r_cy[k] <= w_add[k][SLICE_W];
        end
      end
    end
  end

`ifdef HW_ADDER_FLAGS_EN
  logic r_c_carry;
  logic r_c_ovf;
  logic w_ovf;

  // Overflow: operands agree in sign but the result sign differs.
  assign w_ovf = (w_a_in[N-1][63] == w_b_in[N-1][63]) &&
                 (w_sum_nxt[N-1][63] != w_a_in[N-1][63]);

  // Flags are captured with the final slice so they line up with c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_carry <= 1'b0;
      r_c_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_c_carry <= w_add[N-1][SLICE_W];
      r_c_ovf   <= w_ovf;
    end
  end

  assign c_carry = r_c_carry;
  assign c_ovf   = r_c_ovf;
`endif

endmodule

// File: tb/tb_hardware_adder_64bit_pipe.sv
// Testbench for hardware_adder_64bit_pipe (SLICE_W=16, 4-stage latency).
// Scoreboard: accepted inputs push a 65-bit arithmetic reference result;
// a negedge monitor pops and compares on every output transfer.
module tb_hardware_adder_64bit_pipe;

  localparam int SLICE_W = 16;
  localparam int N       = 64 / SLICE_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [63:0] c;
`ifdef HW_ADDER_FLAGS_EN
  logic        c_carry;
  logic        c_ovf;
`endif

  hardware_adder_64bit_pipe #(.SLICE_W(SLICE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
`ifdef HW_ADDER_FLAGS_EN
    ,
    .c_carry   (c_carry),
    .c_ovf     (c_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] c;
    logic        cy;
    logic        ov;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          lat_mode = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_c = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 65-bit addition, flags from operand/result signs.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                 input int t, input bit l);
    exp_t        r;
    logic [64:0] s;
    s     = {1'b0, x} + {1'b0, y};
    r.c   = s[63:0];
    r.cy  = s[64];
    r.ov  = (x[63] == y[63]) && (s[63] != x[63]);
    r.cyc = t;
    r.lat = l;
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 6))
      0: v = 64'hFFFF_FFFF_FFFF_FFFF;
      1: v = 64'h7FFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'h0;
      4: v[31:0] = 32'hFFFF_FFFF;
      default: ;
    endcase
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and scoreboard push, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_out_valid_hold", out_valid, 1);
        check("stall_c_hold", c, prev_c);
      end
      if (out_valid && !out_ready) check("in_ready_low_on_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got c=0x%h with no pending transaction (t=%0t)", c, $time);
        end else begin
          e = sb.pop_front();
          check("sum", c, e.c);
`ifdef HW_ADDER_FLAGS_EN
          check("c_carry", c_carry, e.cy);
          check("c_ovf", c_ovf, e.ov);
`endif
          if (e.lat) check("latency", cyc - e.cyc, N);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_c     = c;
      if (in_valid && in_ready) sb.push_back(model(a, b, cyc, lat_mode));
    end
  end

  task automatic send(input logic [63:0] x, input logic [63:0] y);
    int t;
    t = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
`ifdef HW_ADDER_FLAGS_EN
    check("rst_c_carry", c_carry, 0);
    check("rst_c_ovf", c_ovf, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1);

    // Directed corner vectors with latency tracking
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    send(64'h0000_0000_FFFF_FFFF, 64'h1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    drain();

    // Eight back-to-back transfers: each must emerge exactly N cycles later
    for (int i = 0; i < 8; i++) send(rand64(), rand64());
    drain();

    // Stream with a 10-cycle output stall
    lat_mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid  = 1'b1;
      a         = rand64();
      b         = rand64();
      out_ready = !(i >= 4 && i < 14);
      #1;
      if (i == 10) check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    drain();

    // Random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = rand64();
      b         = rand64();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    // Reset with three transactions in flight
    lat_mode = 1'b1;
    send(64'h1111, 64'h2222);
    send(64'h3333, 64'h4444);
    send(64'h5555, 64'h6666);
    #2;
    rst_n = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_c", c, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_mid_rst", in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    check("no_stale_out_valid", out_valid, 0);

    // Sanity after reset
    send(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001);
    send(64'hDEAD_BEEF_0000_FFFF, 64'h0123_4567_FFFF_0001);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
